// File: rtl/neuron_mac_seq.sv
// Sequential MAC neuron: streams N activations against a per-neuron weight BRAM,
// adds bias, rescales, saturates (optional ReLU) and hands the result over valid/ready.
module neuron_mac_seq #(
    parameter int N         = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int RELU      = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    input  logic [DATA_W-1:0] X_IN,
    input  logic              X_VALID,
    output logic              X_READY,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              W_WE,
    input  logic [DATA_W-1:0] W_DO,
    output logic [DATA_W-1:0] Y_OUT,
    output logic              Y_VALID,
    input  logic              Y_READY,
    output logic              BUSY,
    output logic [2:0]        DBG_STATE
);

    // Handshakes: a transfer happens on any posedge where valid and ready are both high;
    // X_READY depends only on state, Y_VALID/Y_OUT stay stable until Y_READY is seen.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic signed [ACC_W:0] S_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] S_MIN = ~S_MAX;

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_W-1:0]          idx;
    logic signed [ACC_W-1:0]    acc;
    logic                       mac_v;
    logic [DATA_W-1:0]          x_q;
    logic [DATA_W-1:0]          bias_q;
    logic                       x_hs;
    logic                       last_in;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_sh;
    logic signed [ACC_W:0]      s_full;
    logic signed [DATA_W-1:0]   y_sat;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        X_READY   = 1'b0;
        W_EN      = 1'b0;
        BUSY      = 1'b1;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nxt = S_RUN;
            end
            S_RUN: begin
                X_READY = 1'b1;
                W_EN    = X_VALID;
                if (X_VALID && last_in) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  if (Y_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign x_hs      = X_VALID & X_READY;
    assign last_in   = (idx == ADDR_W'(N-1));
    assign W_ADDR    = idx;
    assign W_WE      = 1'b0;
    assign DBG_STATE = state;

    // W_DO carries the weight for x_q one edge after the handshake that fetched it.
    assign prod   = $signed(x_q) * $signed(W_DO);
    assign acc_sh = acc >>> FRAC_BITS;
    assign s_full = {acc_sh[ACC_W-1], acc_sh}
                  + {{(ACC_W+1-DATA_W){bias_q[DATA_W-1]}}, bias_q};

    always_comb begin
        y_sat = s_full[DATA_W-1:0];
        if (s_full > S_MAX)      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (s_full < S_MIN) y_sat = {1'b1, {(DATA_W-1){1'b0}}};
        if (RELU != 0 && y_sat[DATA_W-1]) y_sat = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx     <= '0;
            acc     <= '0;
            mac_v   <= 1'b0;
            x_q     <= '0;
            bias_q  <= '0;
            Y_OUT   <= '0;
            Y_VALID <= 1'b0;
        end else begin
            if (state == S_IDLE && START) begin
                acc    <= '0;
                idx    <= '0;
                bias_q <= BIAS;
            end else if (mac_v) begin
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            end
            // idx wraps to 0 on the last input so W_ADDR never leaves 0..N-1.
            if (x_hs) begin
                x_q <= X_IN;
                idx <= last_in ? '0 : idx + 1'b1;
            end
            mac_v <= x_hs;
            if (state == S_FINAL) begin
                Y_OUT   <= y_sat;
                Y_VALID <= 1'b1;
            end else if (state == S_DONE && Y_READY) begin
                Y_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: BRAM model with negedge read data, plain-arithmetic reference
// neuron, and one task per scenario; a RELU=1 copy runs in lockstep on the same stimulus.
module tb_neuron_mac_seq;
    localparam int N = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        x_valid = 1'b0;
    logic        y_ready = 1'b0;
    logic [15:0] bias = 16'h0;
    logic [15:0] x_in = 16'h0;
    logic [15:0] w_do = 16'h0;

    logic        x_ready, w_en, w_we, y_valid, busy;
    logic [4:0]  w_addr;
    logic [15:0] y_out;
    logic [2:0]  dbg_state;
    logic        x_ready_r, w_en_r, w_we_r, y_valid_r, busy_r;
    logic [4:0]  w_addr_r;
    logic [15:0] y_out_r;
    logic [2:0]  dbg_state_r;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [N];
    logic [15:0] xs  [N];
    logic        en_q = 1'b0;
    logic [4:0]  addr_q = 5'd0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.RELU(0)) dut (
        .CLK(clk), .RST(rst), .START(start), .BIAS(bias), .X_IN(x_in), .X_VALID(x_valid),
        .X_READY(x_ready), .W_ADDR(w_addr), .W_EN(w_en), .W_WE(w_we), .W_DO(w_do),
        .Y_OUT(y_out), .Y_VALID(y_valid), .Y_READY(y_ready), .BUSY(busy), .DBG_STATE(dbg_state)
    );

    neuron_mac_seq #(.RELU(1)) dut_relu (
        .CLK(clk), .RST(rst), .START(start), .BIAS(bias), .X_IN(x_in), .X_VALID(x_valid),
        .X_READY(x_ready_r), .W_ADDR(w_addr_r), .W_EN(w_en_r), .W_WE(w_we_r), .W_DO(w_do),
        .Y_OUT(y_out_r), .Y_VALID(y_valid_r), .Y_READY(y_ready), .BUSY(busy_r),
        .DBG_STATE(dbg_state_r)
    );

    // Weight BRAM: address captured on posedge, data presented on the following negedge.
    always @(posedge clk) begin
        en_q   <= w_en;
        addr_q <= w_addr;
    end
    always @(negedge clk) if (en_q) w_do <= mem[addr_q];

    function automatic logic [15:0] model_y(input logic signed [15:0] b, input bit relu);
        longint sum = 0;
        longint s;
        for (int i = 0; i < N; i++)
            sum += longint'($signed(xs[i])) * longint'($signed(mem[i]));
        s = (sum >>> 8) + longint'(b);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv);
        for (int i = 0; i < N; i++) begin
            xs[i]  = xv;
            mem[i] = wv;
        end
    endtask

    task automatic run_pass(input logic [15:0] b, input int duty,
                            output logic [15:0] y0, output logic [15:0] y1, output int lat,
                            output int en_cnt, output int addr_bad, output bit timeout);
        int k = 0;
        int cyc = 0;
        bit hs;
        en_cnt = 0; addr_bad = 0; lat = 0; timeout = 1'b0;
        bias  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 16'h0;
        while (k < N && cyc < 2000) begin
            x_valid = ($urandom_range(0, 99) < duty);
            x_in    = x_valid ? xs[k] : 16'($urandom);
            #1;
            hs = x_valid && x_ready;
            if (w_en) begin
                en_cnt++;
                if (w_addr != 5'(k)) addr_bad++;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs) k++;
        end
        x_valid = 1'b0;
        while (!y_valid && lat < 8) begin
            if (w_en) en_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        timeout = !y_valid;
        y0 = y_out;
        y1 = y_out_r;
    endtask

    task automatic release_y();
        y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (y_out !== 16'h0) begin errors++; $display("FAIL reset_y_out got=%h exp=0000", y_out); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
        checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready got=%b exp=0", x_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (w_we !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL reset_w_ctl got=%b%b exp=00", w_we, w_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unity();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        fill(16'h0100, 16'h0100);
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (to) begin errors++; $display("FAIL unity_timeout got=no_y_valid exp=y_valid"); end
        checks++; if (y0 !== 16'h1C00) begin errors++; $display("FAIL unity_y got=%h exp=1c00", y0); end
        checks++; if (y1 !== 16'h1C00) begin errors++; $display("FAIL unity_y_relu got=%h exp=1c00", y1); end
        checks++; if (en_cnt != N) begin errors++; $display("FAIL unity_w_en_pulses got=%0d exp=%0d", en_cnt, N); end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL unity_addr_order got=%0d exp=0", addr_bad); end
        checks++; if (lat < 2 || lat > 3) begin errors++; $display("FAIL unity_latency got=%0d exp=2..3", lat); end
        release_y();
        checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL unity_back_idle got=%b%b exp=00", busy, y_valid); end
    endtask

    task automatic test_bias_relu();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        fill(16'h0100, 16'h0100);
        run_pass(16'hFF00, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (y0 !== 16'h1B00) begin errors++; $display("FAIL bias_neg_y got=%h exp=1b00", y0); end
        release_y();
        fill(16'hFF00, 16'h0100);
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (y0 !== 16'hE400) begin errors++; $display("FAIL neg_sum_y got=%h exp=e400", y0); end
        checks++; if (y1 !== 16'h0000) begin errors++; $display("FAIL neg_sum_relu got=%h exp=0000", y1); end
        release_y();
    endtask

    task automatic test_saturate();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        fill(16'h7FFF, 16'h7FFF);
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (y0 !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h exp=7fff", y0); end
        release_y();
        fill(16'h8001, 16'h7FFF);
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (y0 !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h exp=8000", y0); end
        checks++; if (y1 !== 16'h0000) begin errors++; $display("FAIL sat_neg_relu got=%h exp=0000", y1); end
        release_y();
    endtask

    task automatic test_ramp_backpressure();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        logic [15:0] wv [2] = '{16'h0100, 16'h0008};
        logic [15:0] ev [2] = '{16'h7FFF, 16'h0BD0};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                xs[i]  = 16'(i * 256);
                mem[i] = wv[p];
            end
            run_pass(16'h0000, 50, y0, y1, lat, en_cnt, addr_bad, to);
            checks++; if (y0 !== ev[p]) begin errors++; $display("FAIL ramp_y%0d got=%h exp=%h", p, y0, ev[p]); end
            checks++; if (en_cnt != N) begin errors++; $display("FAIL ramp_w_en%0d got=%0d exp=%0d", p, en_cnt, N); end
            checks++; if (addr_bad != 0) begin errors++; $display("FAIL ramp_addr%0d got=%0d exp=0", p, addr_bad); end
            release_y();
        end
    endtask

    task automatic test_hold_done();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        fill(16'h0100, 16'h0100);
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            @(posedge clk); #1;
            start = 1'b0;
            checks++; if (y_out !== 16'h1C00 || y_valid !== 1'b1) begin errors++; $display("FAIL hold_y c=%0d got=%h/%b exp=1c00/1", c, y_out, y_valid); end
            checks++; if (x_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_ctl c=%0d got=%b%b exp=01", c, x_ready, busy); end
        end
        release_y();
        checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b%b exp=00", busy, y_valid); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_pass();
        logic [15:0] y0, y1; int lat, en_cnt, addr_bad; bit to;
        fill(16'h0100, 16'h0100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x_valid = 1'b1;
            x_in = xs[i];
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (y_out !== 16'h0 || y_valid !== 1'b0) begin errors++; $display("FAIL async_rst_y got=%h/%b exp=0000/0", y_out, y_valid); end
        checks++; if (x_ready !== 1'b0 || busy !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL async_rst_ctl got=%b%b%b exp=000", x_ready, busy, w_en); end
        x_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_pass(16'h0000, 100, y0, y1, lat, en_cnt, addr_bad, to);
        checks++; if (y0 !== 16'h1C00) begin errors++; $display("FAIL rst_rerun_y got=%h exp=1c00", y0); end
        checks++; if (en_cnt != N) begin errors++; $display("FAIL rst_rerun_w_en got=%0d exp=%0d", en_cnt, N); end
        release_y();
    endtask

    task automatic test_random();
        logic [15:0] y0, y1, e0, e1, b; int lat, en_cnt, addr_bad; bit to;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) begin
                if (p % 2 == 0) begin
                    xs[i]  = 16'($signed($urandom_range(0, 1023)) - 512);
                    mem[i] = 16'($signed($urandom_range(0, 1023)) - 512);
                end else begin
                    xs[i]  = 16'($urandom);
                    mem[i] = 16'($urandom);
                end
            end
            b  = 16'($urandom);
            e0 = model_y(b, 1'b0);
            e1 = model_y(b, 1'b1);
            run_pass(b, $urandom_range(30, 100), y0, y1, lat, en_cnt, addr_bad, to);
            checks++; if (y0 !== e0) begin errors++; $display("FAIL rand_y p=%0d got=%h exp=%h", p, y0, e0); end
            checks++; if (y1 !== e1) begin errors++; $display("FAIL rand_y_relu p=%0d got=%h exp=%h", p, y1, e1); end
            checks++; if (en_cnt != N || addr_bad != 0) begin errors++; $display("FAIL rand_w_en p=%0d got=%0d/%0d exp=%0d/0", p, en_cnt, addr_bad, N); end
            release_y();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unity();
        test_bias_relu();
        test_saturate();
        test_ramp_backpressure();
        test_hold_done();
        test_reset_mid_pass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
